// File: rtl/offchip_memory_if.sv
// Request/response bus between the data cache controller (master) and the
// off-chip line memory (slave).
interface offchip_memory_if #(
    parameter int LINE_BITS = 256
);
    logic                 enable_i;
    logic                 write_i;
    logic [31:0]          addr_i;
    logic [LINE_BITS-1:0] data_i;
    logic                 ack_o;
    logic [LINE_BITS-1:0] data_o;
    logic                 busy_o;

    modport master (
        output enable_i, write_i, addr_i, data_i,
        input  ack_o, data_o, busy_o
    );

    modport slave (
        input  enable_i, write_i, addr_i, data_i,
        output ack_o, data_o, busy_o
    );
endinterface

// File: rtl/offchip_memory.sv
// Line-granular off-chip memory model: one outstanding request, fixed access
// latency, single-cycle acknowledge.
module offchip_memory #(
    parameter int LINE_BITS = 256,
    parameter int DEPTH     = 512,
    parameter int LATENCY   = 10
) (
    input logic            clk_i,
    input logic            rst_i,
    offchip_memory_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 wr_q;
    logic [IDX_W-1:0]     idx_q;
    logic [LINE_BITS-1:0] wdata_q;
    logic [LINE_BITS-1:0] rdata_q;
    logic                 ack_q;
    logic                 busy_q;
    logic                 done;

    logic [LINE_BITS-1:0] memory [0:DEPTH-1];

    // Byte offset and bits above the index field are don't-care (index wraps).
    logic unused_addr;
    assign unused_addr = ^{bus.addr_i[31:5+IDX_W], bus.addr_i[4:0]};

    assign done = (state == WAIT) && (cnt == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enable_i) begin
                        wr_q    <= bus.write_i;
                        idx_q   <= bus.addr_i[5 +: IDX_W];
                        wdata_q <= bus.data_i;
                        cnt     <= CNT_W'(LATENCY - 1);
                        state   <= WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= ACK;
                        ack_q <= 1'b1;
                        if (!wr_q) rdata_q <= memory[idx_q];
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ACK: begin
                    state  <= IDLE;
                    ack_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    ack_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage is not reset; a reset coinciding with the completing edge
    // suppresses the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && done && wr_q) memory[idx_q] <= wdata_q;
    end

    assign bus.ack_o  = ack_q;
    assign bus.busy_o = busy_q;
    assign bus.data_o = rdata_q;
endmodule

// File: tb/tb_offchip_memory.sv
// Directed self-checking bench for offchip_memory (LATENCY=10, DEPTH=512).
module tb_offchip_memory;
    localparam int LB  = 256;
    localparam int LAT = 10;

    localparam logic [LB-1:0] P3      = {{7{32'h0303_0303}}, 32'hDEADBEEF};
    localparam logic [LB-1:0] W4      = {8{32'hA5A5_0004}};
    localparam logic [LB-1:0] L4_INIT = {8{32'h4444_4444}};
    localparam logic [LB-1:0] L7_OLD  = {8{32'h7777_0007}};
    localparam logic [LB-1:0] L7_NEW  = {8{32'h1234_5678}};
    localparam logic [LB-1:0] L0      = {8{32'h0BAD_F00D}};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    offchip_memory_if #(.LINE_BITS(LB)) bus ();

    offchip_memory #(.LINE_BITS(LB), .DEPTH(512), .LATENCY(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a request on the next rising edge (E0), then withdraw enable.
    task automatic issue(input logic w, input logic [31:0] a, input logic [LB-1:0] d);
        @(negedge clk);
        bus.enable_i = 1'b1;
        bus.write_i  = w;
        bus.addr_i   = a;
        bus.data_i   = d;
        @(posedge clk);
        #1 bus.enable_i = 1'b0;
    endtask

    // Count falling edges after E0 until ack is seen; ack is expected at LAT+1.
    task automatic wait_ack(output int cyc, output logic got);
        cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.ack_o === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12 rst = 1'b1;
        #1;
        checks++;
        if (bus.ack_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.data_o !== '0) begin
            errors++;
            $display("FAIL reset_async: ack=%b busy=%b data=%h want 0/0/0", bus.ack_o, bus.busy_o, bus.data_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_preload();
        int cyc; logic got;
        logic [31:0] addrs [4] = '{32'h60, 32'h80, 32'hE0, 32'h0};
        logic [LB-1:0] vals [4];
        vals = '{P3, L4_INIT, L7_OLD, L0};
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, addrs[i], vals[i]);
            wait_ack(cyc, got);
            checks++;
            if (!got || cyc != LAT + 1) begin
                errors++;
                $display("FAIL preload_write_%0d: got=%b cycle=%0d want ack at %0d", i, got, cyc, LAT + 1);
            end
            checks++;
            if (bus.data_o !== '0) begin
                errors++;
                $display("FAIL write_no_data_%0d: data=%h want 0", i, bus.data_o);
            end
        end
    endtask

    task automatic test_read_latency();
        int busy_cnt = 0;
        issue(1'b0, 32'h60, '0);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (bus.busy_o === 1'b1) busy_cnt++;
            checks++;
            if (bus.ack_o !== (k == LAT + 1)) begin
                errors++;
                $display("FAIL read_ack_k%0d: ack=%b want %b", k, bus.ack_o, (k == LAT + 1));
            end
            if (k >= LAT + 1) begin
                checks++;
                if (bus.data_o !== P3) begin
                    errors++;
                    $display("FAIL read_data_k%0d: data=%h want %h", k, bus.data_o, P3);
                end
            end
        end
        checks++;
        if (busy_cnt != LAT + 1) begin
            errors++;
            $display("FAIL read_busy_len: busy cycles=%0d want %0d", busy_cnt, LAT + 1);
        end
    endtask

    task automatic test_write_read();
        int cyc; logic got;
        issue(1'b1, 32'h80, W4);
        wait_ack(cyc, got);
        checks++;
        if (!got || bus.data_o !== P3) begin
            errors++;
            $display("FAIL write_keeps_data: got=%b data=%h want %h", got, bus.data_o, P3);
        end
        issue(1'b0, 32'h9C, '0);
        wait_ack(cyc, got);
        checks++;
        if (!got || cyc != LAT + 1 || bus.data_o !== W4) begin
            errors++;
            $display("FAIL write_then_read: got=%b cycle=%0d data=%h want %h", got, cyc, bus.data_o, W4);
        end
    endtask

    task automatic test_isolation();
        int cyc; logic got;
        issue(1'b0, 32'h60, '0);
        @(negedge clk);
        bus.addr_i  = 32'h80;
        bus.write_i = 1'b1;
        bus.data_i  = {8{$urandom()}};
        wait_ack(cyc, got);
        checks++;
        if (!got || cyc != LAT || bus.data_o !== P3) begin
            errors++;
            $display("FAIL isolation_read: got=%b cycle=%0d data=%h want %h", got, cyc, bus.data_o, P3);
        end
        issue(1'b0, 32'h80, '0);
        wait_ack(cyc, got);
        checks++;
        if (!got || bus.data_o !== W4) begin
            errors++;
            $display("FAIL isolation_line4: got=%b data=%h want %h", got, bus.data_o, W4);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; logic got;
        int acks = 0;
        issue(1'b1, 32'hE0, L7_NEW);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.ack_o !== 1'b0 || bus.data_o !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%b ack=%b data=%h want 0/0/0", bus.busy_o, bus.ack_o, bus.data_o);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.ack_o === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL reset_mid_no_ack: acks=%0d want 0", acks);
        end
        issue(1'b0, 32'hE0, '0);
        wait_ack(cyc, got);
        checks++;
        if (!got || cyc != LAT + 1 || bus.data_o !== L7_OLD) begin
            errors++;
            $display("FAIL reset_mid_line7: got=%b cycle=%0d data=%h want %h", got, cyc, bus.data_o, L7_OLD);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.enable_i = 1'b1;
        bus.write_i  = 1'b0;
        bus.addr_i   = 32'h4000;
        @(posedge clk);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            checks++;
            if (bus.ack_o !== (k == 11 || k == 23)) begin
                errors++;
                $display("FAIL b2b_ack_k%0d: ack=%b want %b", k, bus.ack_o, (k == 11 || k == 23));
            end
            if (k == 11 || k == 23) begin
                checks++;
                if (bus.data_o !== L0) begin
                    errors++;
                    $display("FAIL b2b_data_k%0d: data=%h want %h", k, bus.data_o, L0);
                end
            end
        end
        bus.enable_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b want 0", bus.busy_o);
        end
    endtask

    initial begin
        bus.enable_i = 1'b0;
        bus.write_i  = 1'b0;
        bus.addr_i   = '0;
        bus.data_i   = '0;
        test_reset();
        test_preload();
        test_read_latency();
        test_write_read();
        test_isolation();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/offchip_memory.md
# offchip_memory

Line-granular off-chip data memory model that acts as the responder for the data cache controller's refill/write-back requests. It accepts one request at a time, holds it for a fixed access latency, then completes it with a one-cycle acknowledge. It sits below the data cache in the pipelined CPU's memory hierarchy and replaces the single-cycle data memory as the backing store.

## Interface
- LINE_BITS, 256, width of one memory line (32 bytes)
- DEPTH, 512, number of lines; power of two
- LATENCY, 10, cycles from request acceptance to acknowledge; must be ≥1
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- enable_i  input  1  request valid; sampled only in IDLE
- write_i  input  1  1 = write line, 0 = read line
- addr_i  input  32  byte address; line index = addr_i[5+log2(DEPTH)-1:5]
- data_i  input  LINE_BITS  write data
- ack_o  output  1  request complete; high exactly one cycle
- data_o  output  LINE_BITS  read data; valid with ack_o on reads and held afterwards
- busy_o  output  1  high while a request is outstanding (state ≠ IDLE)

## Operation
- Storage: array `memory[0:DEPTH-1]` of LINE_BITS. Not reset; benches preload it hierarchically.
- Address: byte-offset bits [4:0] are ignored. Bits above the index field are ignored, so the index wraps modulo DEPTH.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: if enable_i=1, latch write_i, the line index and data_i; load cnt ← LATENCY-1; go to WAIT. Otherwise stay in IDLE.
  - WAIT: if cnt=0, go to ACK and perform the access on that same edge. Otherwise cnt ← cnt-1.
  - ACK: ack_o=1; go to IDLE unconditionally. enable_i is ignored in this state.
- Access on the WAIT→ACK edge:
  - read: data_o ← memory[idx].
  - write: memory[idx] ← latched data; data_o unchanged.
- All inputs are ignored outside IDLE. Changes to addr_i, data_i or write_i during WAIT or ACK do not affect the outstanding request.
- data_o keeps its last read value until the next read completes.
- busy_o = (state ≠ IDLE); ack_o = (state = ACK). Both are state-decoded from registers; no combinational path from inputs to outputs.
- Reset (asynchronous, any time): state ← IDLE, cnt ← 0, ack_o=0, busy_o=0, data_o ← 0.
  - Reset mid-request aborts it: no ack, no memory write.
  - Reset asserted on the completing edge wins; the write is not performed.

## Timing
- Request accepted at edge E0, i.e. the first rising edge with state=IDLE and enable_i=1.
- cnt = LATENCY-1-k after edge E(k), for k = 0..LATENCY-1.
- ack_o is high from E(LATENCY) to E(LATENCY+1); read data_o is valid from E(LATENCY).
- busy_o is high from E0 to E(LATENCY+1), i.e. LATENCY+1 cycles.
- LATENCY=1: ack_o is high in the second cycle after acceptance.
- Back-to-back: with enable_i held high, the next request is accepted at E(LATENCY+2). There is one mandatory IDLE cycle, giving a period of LATENCY+2 cycles.
- The requester is expected to drop enable_i in the ack cycle. If it does not, the request is treated as a new request in the following IDLE cycle.

## Test plan
- Reset: assert rst_i between edges → ack_o=0, busy_o=0, data_o=0 immediately, without waiting for a clock edge.
- Read latency:
  - stimulus: preload memory[3]=0x…DEADBEEF pattern; pulse enable_i=1, write_i=0, addr_i=0x60 at E0.
  - response: busy_o=1 for 11 cycles; ack_o=1 only in the cycle after E10; data_o=pattern from E10 onward.
- Write then read:
  - stimulus: write data_i={8{32'hA5A5_0004}} to addr_i=0x80; on the write ack, data_o is unchanged. Then read addr_i=0x9C.
  - response: read returns {8{32'hA5A5_0004}} (same line 4, offset ignored).
- Input isolation:
  - stimulus: accept a read of line 3; during WAIT change addr_i=0x80, write_i=1 and data_i to random values.
  - response: the ack returns the line 3 contents; memory[4] is unchanged.
- Reset mid-operation:
  - stimulus: start a write of 0x1234… to line 7; assert rst_i 5 cycles after acceptance.
  - response: no ack and memory[7] keeps its old value. After reset release, a read of line 7 completes normally in 10 cycles.
- Wrap and back-to-back:
  - stimulus: hold enable_i=1 with addr_i=0x4000.
  - response: the request maps to line 0; acks occur at E10 and E22 (12-cycle period), and each one returns memory[0].
